// File: rtl/uart_transceiver.sv
// uart_transceiver: full-duplex UART with a small TX FIFO, a single-entry RX
// holding register and sticky RX error flags. Core side is valid/ready; the
// serial side is idle-high with start, LSB-first data, optional parity, stop.
module uart_transceiver #(
   parameter int CLKS_PER_BIT  = 16,
   parameter int DATA_BITS     = 8,
   parameter int PARITY        = 0,
   parameter int TX_FIFO_DEPTH = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 uart_tx,
   input  logic                 uart_rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err,
   output logic                 rx_overrun,
   input  logic                 err_clear
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam int PW = $clog2(TX_FIFO_DEPTH);
   localparam int FW = PW + 1;
   localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF   = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS - 1);
   localparam logic [FW-1:0] FIFO_FULL  = FW'(TX_FIFO_DEPTH);
   localparam logic          HAS_PARITY = (PARITY != 0);
   localparam logic          ODD_PARITY = (PARITY == 2);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   // ---------------- TX FIFO ----------------
   logic [DATA_BITS-1:0] fifo_mem [TX_FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr_reg, rd_ptr_reg;
   logic [FW-1:0]        fifo_count_reg;
   logic                 push, pop;
   logic [DATA_BITS-1:0] fifo_head;

   assign tx_ready  = (fifo_count_reg != FIFO_FULL);
   assign push      = tx_valid && tx_ready;
   assign fifo_head = fifo_mem[rd_ptr_reg];

   // FIFO storage: written on push only, contents need no reset
   always_ff @(posedge clock) begin
      if (push) fifo_mem[wr_ptr_reg] <= tx_data;
   end

   // FIFO pointers and occupancy; pointers wrap naturally
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         fifo_count_reg <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
         case ({push, pop})
            2'b10:   fifo_count_reg <= fifo_count_reg + FW'(1);
            2'b01:   fifo_count_reg <= fifo_count_reg - FW'(1);
            default: fifo_count_reg <= fifo_count_reg;
         endcase
      end
   end

   // ---------------- TX FSM ----------------
   state_t               tx_state_reg, tx_state_next;
   logic [CW-1:0]        tx_cnt_reg, tx_cnt_next;
   logic [BW-1:0]        tx_bit_reg, tx_bit_next;
   logic [DATA_BITS-1:0] tx_shift_reg, tx_shift_next;
   logic                 tx_par_reg, tx_par_next;
   logic                 tx_line_reg, tx_line_next;
   logic                 tx_tick;

   assign tx_tick = (tx_cnt_reg == CNT_LAST);
   assign uart_tx = tx_line_reg;

   // TX state register; the line itself is registered so it is glitch-free
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tx_state_reg <= S_IDLE;
         tx_cnt_reg   <= '0;
         tx_bit_reg   <= '0;
         tx_shift_reg <= '0;
         tx_par_reg   <= 1'b0;
         tx_line_reg  <= 1'b1;
      end else begin
         tx_state_reg <= tx_state_next;
         tx_cnt_reg   <= tx_cnt_next;
         tx_bit_reg   <= tx_bit_next;
         tx_shift_reg <= tx_shift_next;
         tx_par_reg   <= tx_par_next;
         tx_line_reg  <= tx_line_next;
      end
   end

   // TX next state; the line value follows the state being entered
   always_comb begin
      tx_state_next = tx_state_reg;
      tx_cnt_next   = tx_tick ? '0 : tx_cnt_reg + CW'(1);
      tx_bit_next   = tx_bit_reg;
      tx_shift_next = tx_shift_reg;
      tx_par_next   = tx_par_reg;
      tx_line_next  = 1'b1;
      pop           = 1'b0;
      case (tx_state_reg)
         S_IDLE: begin
            tx_cnt_next = '0;
            if (fifo_count_reg != '0) pop = 1'b1;
         end
         S_START: if (tx_tick) begin
            tx_state_next = S_DATA;
            tx_bit_next   = '0;
         end
         S_DATA: if (tx_tick) begin
            tx_shift_next = tx_shift_reg >> 1;
            tx_bit_next   = tx_bit_reg + BW'(1);
            if (tx_bit_reg == BIT_LAST) tx_state_next = HAS_PARITY ? S_PARITY : S_STOP;
         end
         S_PARITY: if (tx_tick) tx_state_next = S_STOP;
         S_STOP: if (tx_tick) begin
            // back-to-back frames: reload straight into START with no idle gap
            if (fifo_count_reg != '0) pop = 1'b1;
            else                      tx_state_next = S_IDLE;
         end
         default: tx_state_next = S_IDLE;
      endcase
      if (pop) begin
         tx_state_next = S_START;
         tx_cnt_next   = '0;
         tx_shift_next = fifo_head;
         tx_par_next   = (^fifo_head) ^ ODD_PARITY;
      end
      case (tx_state_next)
         S_START:  tx_line_next = 1'b0;
         S_DATA:   tx_line_next = tx_shift_next[0];
         S_PARITY: tx_line_next = tx_par_next;
         default:  tx_line_next = 1'b1;
      endcase
   end

   // ---------------- RX ----------------
   logic                 rx_meta_reg, rx_sync_reg, rx_armed_reg;
   state_t               rx_state_reg, rx_state_next;
   logic [CW-1:0]        rx_cnt_reg, rx_cnt_next;
   logic [BW-1:0]        rx_bit_reg, rx_bit_next;
   logic [DATA_BITS-1:0] rx_shift_reg, rx_shift_next;
   logic                 rx_par_reg, rx_par_next;
   logic                 rx_tick, deliver, frame_bad, parity_bad, drop;

   assign rx_tick    = (rx_cnt_reg == CNT_LAST);
   assign frame_bad  = !rx_sync_reg;
   assign parity_bad = HAS_PARITY && (rx_par_reg ^ (^rx_shift_reg) ^ ODD_PARITY);
   assign drop       = rx_valid && !rx_ready;

   // Two-flop synchroniser; arming waits for an idle-high line after reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_meta_reg  <= 1'b1;
         rx_sync_reg  <= 1'b1;
         rx_armed_reg <= 1'b0;
      end else begin
         rx_meta_reg  <= uart_rx;
         rx_sync_reg  <= rx_meta_reg;
         rx_armed_reg <= rx_armed_reg | rx_sync_reg;
      end
   end

   // RX state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_state_reg <= S_IDLE;
         rx_cnt_reg   <= '0;
         rx_bit_reg   <= '0;
         rx_shift_reg <= '0;
         rx_par_reg   <= 1'b0;
      end else begin
         rx_state_reg <= rx_state_next;
         rx_cnt_reg   <= rx_cnt_next;
         rx_bit_reg   <= rx_bit_next;
         rx_shift_reg <= rx_shift_next;
         rx_par_reg   <= rx_par_next;
      end
   end

   // RX next state: half-bit start check, then mid-bit sampling
   always_comb begin
      rx_state_next = rx_state_reg;
      rx_cnt_next   = rx_tick ? '0 : rx_cnt_reg + CW'(1);
      rx_bit_next   = rx_bit_reg;
      rx_shift_next = rx_shift_reg;
      rx_par_next   = rx_par_reg;
      deliver       = 1'b0;
      case (rx_state_reg)
         S_IDLE: begin
            rx_cnt_next = '0;
            if (rx_armed_reg && !rx_sync_reg) rx_state_next = S_START;
         end
         S_START: if (rx_cnt_reg == CNT_HALF) begin
            rx_cnt_next = '0;
            if (rx_sync_reg) begin
               rx_state_next = S_IDLE;
            end else begin
               rx_state_next = S_DATA;
               rx_bit_next   = '0;
            end
         end
         S_DATA: if (rx_tick) begin
            rx_shift_next = {rx_sync_reg, rx_shift_reg[DATA_BITS-1:1]};
            rx_bit_next   = rx_bit_reg + BW'(1);
            if (rx_bit_reg == BIT_LAST) rx_state_next = HAS_PARITY ? S_PARITY : S_STOP;
         end
         S_PARITY: if (rx_tick) begin
            rx_par_next   = rx_sync_reg;
            rx_state_next = S_STOP;
         end
         S_STOP: if (rx_tick) begin
            deliver       = 1'b1;
            rx_state_next = S_IDLE;
         end
         default: rx_state_next = S_IDLE;
      endcase
   end

   // Holding register and sticky flags; setting wins over err_clear
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         rx_parity_err <= 1'b0;
         rx_frame_err  <= 1'b0;
         rx_overrun    <= 1'b0;
      end else begin
         if (deliver && !drop) begin
            rx_data  <= rx_shift_reg;
            rx_valid <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
         if (deliver && frame_bad)  rx_frame_err  <= 1'b1;
         else if (err_clear)        rx_frame_err  <= 1'b0;
         if (deliver && parity_bad) rx_parity_err <= 1'b1;
         else if (err_clear)        rx_parity_err <= 1'b0;
         if (deliver && drop)       rx_overrun    <= 1'b1;
         else if (err_clear)        rx_overrun    <= 1'b0;
      end
   end
endmodule

// File: tb/tb_uart_transceiver.sv
// tb_uart_transceiver: directed stimulus with queue-based scoreboards. Two
// monitors decode the serial TX line and the RX handshake and compare against
// hand-computed expectations. DUT runs with even parity, 16 clocks/bit, 8 bits.
`timescale 1ns/1ps
module tb_uart_transceiver;
   localparam int CPB = 16;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       uart_tx;
   logic       uart_rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       rx_parity_err;
   logic       rx_frame_err;
   logic       rx_overrun;
   logic       err_clear;

   logic       loop_en;
   logic       rx_drive;
   logic       tx_mon_en;
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;

   logic [8:0]  tx_exp_q[$];   // {parity, data}
   logic [10:0] rx_exp_q[$];   // {overrun, frame_err, parity_err, data}
   int          tx_start_q[$];

   // 0xA5 frame, bit 0 first: start 0, data 1,0,1,0,0,1,0,1, parity 0, stop 1
   logic [10:0] a5_bits = 11'b10101001010;
   // 0x01..0x06 with even parity: 1,1,0,1,0,0
   logic [8:0]  burst_exp [6] = '{9'h101, 9'h102, 9'h003, 9'h104, 9'h005, 9'h006};

   assign uart_rx = loop_en ? uart_tx : rx_drive;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   uart_transceiver #(
      .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .TX_FIFO_DEPTH(4)
   ) dut (
      .clock(clock), .reset(reset),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .uart_tx(uart_tx), .uart_rx(uart_rx),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
      .rx_overrun(rx_overrun), .err_clear(err_clear)
   );

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while ((tx_exp_q.size() != 0 || rx_exp_q.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      check("drain_timeout", (n >= budget), 0);
   endtask

   // Drive one serial frame onto uart_rx (even parity, chosen stop level)
   task automatic send_rx(input logic [7:0] d, input logic stop);
      logic [10:0] f;
      f = {stop, ^d, d, 1'b0};
      for (int i = 0; i < 11; i++) begin
         rx_drive = f[i];
         repeat (CPB) tick();
      end
      rx_drive = 1'b1;
   endtask

   // TX monitor: decode each frame at bit centres and compare
   initial begin : tx_monitor
      logic        prev;
      logic [10:0] bits;
      logic [8:0]  exp;
      int          s;
      prev = 1'b1;
      forever begin
         @(negedge clock);
         if (prev === 1'b1 && uart_tx === 1'b0) begin
            s = cyc;
            repeat (CPB / 2) @(negedge clock);
            bits[0] = uart_tx;
            for (int i = 1; i < 11; i++) begin
               repeat (CPB) @(negedge clock);
               bits[i] = uart_tx;
            end
            prev = uart_tx;
            if (tx_mon_en) begin
               tx_start_q.push_back(s);
               if (tx_exp_q.size() == 0) begin
                  check("tx_unexpected_frame", bits, 0);
               end else begin
                  exp = tx_exp_q.pop_front();
                  check("tx_frame", bits, {1'b1, exp[8], exp[7:0], 1'b0});
               end
            end
         end else begin
            prev = uart_tx;
         end
      end
   end

   // RX monitor: compare data and flags on every accepted handshake
   initial begin : rx_monitor
      logic [10:0] exp;
      forever begin
         @(negedge clock);
         if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
            if (rx_exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL rx_unexpected got=%02h want=none", rx_data);
            end else begin
               exp = rx_exp_q.pop_front();
               check("rx_frame", {rx_overrun, rx_frame_err, rx_parity_err, rx_data}, exp);
            end
         end
      end
   end

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      int n;
      tx_data = '0; tx_valid = 0; rx_ready = 1; err_clear = 0;
      loop_en = 0; rx_drive = 1; tx_mon_en = 1;
      #2 reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      tick();

      // reset state
      check("rst_uart_tx", uart_tx, 1);
      check("rst_tx_ready", tx_ready, 1);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_flags", {rx_parity_err, rx_frame_err, rx_overrun}, 0);
      repeat (5) tick();

      // single frame 0xA5, cycle-exact waveform
      tx_data = 8'hA5; tx_valid = 1;
      tx_exp_q.push_back({1'b0, 8'hA5});
      tick();
      tx_valid = 0;
      check("tx_idle_c1", uart_tx, 1);
      for (int c = 2; c < 178; c++) begin
         tick();
         check("tx_wave", uart_tx, a5_bits[(c - 2) / 16]);
         if ((c - 2) % 16 == 0) check("tx_ready_hold", tx_ready, 1);
      end
      tick();
      check("tx_idle_after", uart_tx, 1);
      wait_drain(100);
      repeat (10) tick();

      // burst of six into a four-deep FIFO
      tx_start_q.delete();
      c0 = cyc;
      for (int i = 0; i < 6; i++) begin
         tx_data = 8'(i + 1);
         tx_valid = 1;
         if (i == 5) begin
            check("tx_ready_full", tx_ready, 0);
            n = 0;
            while (!tx_ready && n < 400) begin
               tick();
               n++;
            end
            check("tx_accept6_cycle", cyc - c0, 178);
         end
         tx_exp_q.push_back(burst_exp[i]);
         tick();
      end
      tx_valid = 0;
      wait_drain(1500);
      check("tx_frame_count", tx_start_q.size(), 6);
      for (int i = 1; i < tx_start_q.size(); i++)
         check("tx_no_gap", tx_start_q[i] - tx_start_q[i-1], 176);
      repeat (20) tick();

      // loopback 0x3C, parity bit 0
      loop_en = 1; rx_ready = 1;
      repeat (5) tick();
      tx_data = 8'h3C; tx_valid = 1;
      tx_exp_q.push_back({1'b0, 8'h3C});
      rx_exp_q.push_back({3'b000, 8'h3C});
      tick();
      tx_valid = 0;
      wait_drain(400);
      repeat (20) tick();
      check("loop_rx_valid_done", rx_valid, 0);
      loop_en = 0;
      repeat (10) tick();

      // framing error on 0x55, sticky until cleared
      rx_exp_q.push_back({1'b0, 1'b1, 1'b0, 8'h55});
      send_rx(8'h55, 1'b0);
      repeat (30) tick();
      check("rx_data_55", rx_data, 8'h55);
      check("rx_frame_err_held", rx_frame_err, 1);
      check("rx_drain_fe", rx_exp_q.size(), 0);
      err_clear = 1;
      tick();
      err_clear = 0;
      tick();
      check("rx_frame_err_clear", rx_frame_err, 0);
      repeat (10) tick();

      // overrun: 0x11 held, 0x22 dropped
      rx_ready = 0;
      rx_exp_q.push_back({1'b1, 1'b0, 1'b0, 8'h11});
      send_rx(8'h11, 1'b1);
      send_rx(8'h22, 1'b1);
      repeat (10) tick();
      check("ovr_rx_valid", rx_valid, 1);
      check("ovr_rx_data", rx_data, 8'h11);
      check("ovr_flag", rx_overrun, 1);
      rx_ready = 1;
      tick();
      tick();
      check("ovr_consumed", rx_valid, 0);
      check("rx_drain_ovr", rx_exp_q.size(), 0);
      err_clear = 1;
      tick();
      err_clear = 0;
      tick();
      check("ovr_clear", rx_overrun, 0);
      repeat (10) tick();

      // 4-cycle glitch is a false start
      rx_drive = 0;
      repeat (4) tick();
      rx_drive = 1;
      repeat (40) tick();
      check("glitch_rx_valid", rx_valid, 0);
      check("glitch_flags", {rx_parity_err, rx_frame_err, rx_overrun}, 0);

      // asynchronous reset in the middle of a data bit
      tx_mon_en = 0;
      tx_data = 8'h00; tx_valid = 1;
      tick();
      tick();
      tx_valid = 0;
      repeat (38) tick();
      check("tx_mid_frame_low", uart_tx, 0);
      reset = 1;
      #1;
      check("rst_async_uart_tx", uart_tx, 1);
      check("rst_async_tx_ready", tx_ready, 1);
      tick();
      tick();
      reset = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         check("rst_fifo_empty_line", uart_tx, 1);
      end
      check("rst_fifo_ready", tx_ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
